// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with thresholds, occupancy, error pulses and FWFT mode; read latency 1 cycle (FWFT=0) or 0 (FWFT=1).
// Writes are rejected while full unless a read is accepted on the same edge; rejections pulse overflow/underflow.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       r_en,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  rd_acc, wr_acc;

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign data_out     = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;

   always_comb begin
      rd_acc   = r_en && !empty;
      // A full FIFO still takes a write when the head leaves on the same edge.
      wr_acc   = w_en && (!full || r_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      if (wr_acc) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
         dout_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      ovf_d   = w_en && full && !r_en;
      udf_d   = r_en && empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately not cleared by reset; the pointers make old words unreachable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard-read instance plus an FWFT instance.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst, w_en, r_en;
   logic [7:0] data_in, data_out;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   logic       f_rst, f_w_en, f_r_en;
   logic [7:0] f_data_in, f_data_out;
   logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
   logic [4:0] f_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sync_fifo_param dut (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_param #(.FWFT(1)) dut_f (
      .clk(clk), .rst(f_rst), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
      .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
      .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_dout;
      logic       w, r, rd, wr, exp_ovf, exp_udf, rst_done;
      logic [7:0] d;

      f_rst = 1'b1; f_w_en = 1'b0; f_r_en = 1'b0; f_data_in = 8'h00;

      // Reset with both requests high: reset must dominate.
      rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hFF;
      step(); step();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_aempty", almost_empty, 1);
      check("rst_full", full, 0);
      check("rst_afull", almost_full, 0);
      check("rst_dout", data_out, 8'h00);
      check("rst_ovf", overflow, 0);
      check("rst_udf", underflow, 0);
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
      step();

      // Fill 0x00..0x0F, watching the threshold flags.
      for (int i = 0; i < 16; i++) begin
         w_en = 1'b1; data_in = 8'(i);
         step();
         check("fill_count", count, i + 1);
         check("fill_aempty", almost_empty, (i + 1) <= 2);
         check("fill_afull", almost_full, (i + 1) >= 12);
         check("fill_full", full, (i + 1) == 16);
      end
      data_in = 8'hAA;
      step();
      check("ovf_pulse", overflow, 1);
      check("ovf_count", count, 16);
      w_en = 1'b0;
      step();
      check("ovf_clear", overflow, 0);

      // Full pass-through: 0x00 leaves, 0x55 enters.
      w_en = 1'b1; r_en = 1'b1; data_in = 8'h55;
      step();
      check("pass_count", count, 16);
      check("pass_ovf", overflow, 0);
      check("pass_dout", data_out, 8'h00);
      w_en = 1'b0;
      for (int j = 0; j < 16; j++) begin
         step();
         check("drain_dout", data_out, (j < 15) ? j + 1 : 8'h55);
         check("drain_count", count, 15 - j);
      end
      check("drain_empty", empty, 1);

      // Empty corner cases (r_en still high).
      step();
      check("udf_pulse", underflow, 1);
      check("udf_hold", data_out, 8'h55);
      check("udf_count", count, 0);
      w_en = 1'b1; data_in = 8'h77;
      step();
      check("wr_empty_count", count, 1);
      check("wr_empty_udf", underflow, 1);
      check("wr_empty_hold", data_out, 8'h55);
      w_en = 1'b0;
      step();
      check("rd_77", data_out, 8'h77);
      check("rd_77_udf", underflow, 0);
      check("rd_77_count", count, 0);
      r_en = 1'b0;
      step();
      check("udf_idle", underflow, 0);

      // Randomised traffic against a queue model, with one mid-run reset at count 7.
      exp_dout = 8'h77;
      rst_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!rst_done && i >= 60 && q.size() == 7) begin
            rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'h00;
            step();
            rst = 1'b0;
            q.delete();
            exp_dout = 8'h00;
            rst_done = 1'b1;
            check("mid_rst_count", count, 0);
            check("mid_rst_empty", empty, 1);
            check("mid_rst_dout", data_out, 8'h00);
         end else begin
            w = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 7) != 0);
            d = 8'($urandom);
            rd = r && (q.size() > 0);
            wr = w && ((q.size() < 16) || r);
            exp_ovf = w && (q.size() == 16) && !r;
            exp_udf = r && (q.size() == 0);
            if (rd) exp_dout = q.pop_front();
            if (wr) q.push_back(d);
            w_en = w; r_en = r; data_in = d;
            step();
            check("rnd_count", count, q.size());
            check("rnd_dout", data_out, exp_dout);
            check("rnd_ovf", overflow, exp_ovf);
            check("rnd_udf", underflow, exp_udf);
            check("rnd_empty", empty, q.size() == 0);
            check("rnd_full", full, q.size() == 16);
         end
      end
      check("mid_rst_seen", rst_done, 1);
      w_en = 1'b0; r_en = 1'b0;

      // FWFT instance: head word visible immediately after its write edge.
      step();
      f_rst = 1'b0;
      f_w_en = 1'b1; f_data_in = 8'h3C;
      step();
      check("fwft_empty", f_empty, 0);
      check("fwft_head", f_data_out, 8'h3C);
      f_data_in = 8'h3D;
      step();
      check("fwft_count2", f_count, 2);
      check("fwft_head2", f_data_out, 8'h3C);
      f_w_en = 1'b0; f_r_en = 1'b1;
      step();
      check("fwft_pop", f_data_out, 8'h3D);
      check("fwft_count1", f_count, 1);
      step();
      check("fwft_empty2", f_empty, 1);
      check("fwft_udf0", f_underflow, 0);
      step();
      check("fwft_udf", f_underflow, 1);
      f_r_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
